// File: rtl/bram_arbiter.sv
// Two-master round-robin arbiter and sequencer for a single-port block RAM.
// Each access is a fixed IDLE -> ISSUE -> RESP sequence with a registered BRAM command.
module bram_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state;
   logic              last_gnt;
   logic              winner;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              pick_m1;
   logic              in_issue;
   logic              rd_resp;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pick_m1 = 1'b0;
      if (m0_req && m1_req) begin
         pick_m1 = (last_gnt == 1'b0);
      end else begin
         pick_m1 = m1_req;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         winner    <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  winner    <= pick_m1;
                  last_gnt  <= pick_m1;
                  cmd_we    <= pick_m1 ? m1_we    : m0_we;
                  cmd_addr  <= pick_m1 ? m1_addr  : m0_addr;
                  cmd_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                  state     <= ISSUE;
               end
            end
            ISSUE: state <= RESP;
            RESP: begin
               if (!cmd_we) begin
                  rdata_q <= bram_rdata;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode only from registers; requests never reach an output combinationally.
   assign in_issue   = (state == ISSUE);
   assign rd_resp    = (state == RESP) && !cmd_we;

   assign bram_en    = in_issue;
   assign bram_we    = in_issue && cmd_we;
   assign bram_addr  = cmd_addr;
   assign bram_wdata = cmd_wdata;

   assign m0_gnt     = in_issue && !winner;
   assign m1_gnt     = in_issue &&  winner;
   assign m0_rvalid  = rd_resp  && !winner;
   assign m1_rvalid  = rd_resp  &&  winner;

   // Read data passes straight through in RESP and is held afterwards.
   assign rdata      = rd_resp ? bram_rdata : rdata_q;

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-master arbiter and sequencer for the single-port block RAM in the top-level design. It shares the BRAM between the UART loader (master 0) and the address-counter/display scanner (master 1). Each access runs as a fixed three-state sequence with a registered BRAM command. Ties between the masters resolve round-robin, so a continuously requesting master cannot starve the other.

## Interface
- ADDR_W, 11, BRAM address width
- DATA_W, 8, BRAM data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous reset, active low
- m0_req  in  1  master 0 access request, held until m0_gnt
- m0_we  in  1  master 0 write (1) / read (0), valid with m0_req
- m0_addr  in  ADDR_W  master 0 address, valid with m0_req
- m0_wdata  in  DATA_W  master 0 write data, valid with m0_req
- m0_gnt  out  1  one-cycle pulse: master 0 command issued to BRAM
- m0_rvalid  out  1  one-cycle pulse: rdata holds master 0 read result
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as master 0, for master 1
- rdata  out  DATA_W  read data, shared, qualified by mN_rvalid
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data, one cycle after bram_en

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its we/addr/wdata into the command registers, record the winner index, go to ISSUE.
- Arbitration (evaluated only in IDLE):
  - Single requester wins.
  - Both requesting: the master not granted last wins.
  - last_gnt is updated on every grant and resets to 1, so master 0 wins the first tie.
- ISSUE:
  - bram_en=1; bram_we/addr/wdata come from the command registers.
  - The winner's gnt=1, the other gnt=0.
  - Always go to RESP.
- RESP:
  - bram_en=0.
  - If the command was a read: rdata=bram_rdata and the winner's rvalid=1.
  - If the command was a write: both rvalid stay 0.
  - Always go to IDLE.
- Requester rules:
  - Hold req and its qualifiers stable from assertion until its gnt cycle.
  - During the RESP cycle, either drop req or present the next request. The arbiter does not sample requests in ISSUE or RESP.
  - Deasserting req before gnt is a protocol violation. Once latched in IDLE, the access completes regardless.
- Command registers and the winner index change only on the IDLE->ISSUE transition.
- A loser's pending request stays pending and is served next. Worst-case wait is one foreign access (3 cycles) before its own IDLE sample.

## Timing
- Reset, asynchronous, immediate:
  - State=IDLE, last_gnt=1.
  - bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
  - m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, rdata=0.
- All outputs are registered or decoded from the state register only. No combinational path from any req to any output.
- Reset mid-operation aborts the access:
  - No gnt or rvalid is emitted for it afterwards.
  - A write aborted before ISSUE is not performed.
- Request sampled in IDLE at edge T:
  - bram_en and gnt high during cycle T..T+1.
  - rdata/rvalid during T+1..T+2.
  - Back in IDLE at T+2.
- Throughput: one access per 3 cycles. Sustained contention alternates 0,1,0,1,...
- rdata holds its last value outside rvalid cycles.
- Addresses are passed through unmodified. No wrap or range checking; the full 2^ADDR_W space is legal.

## Test plan
- Reset: pulse rst_n low mid-clock, asynchronously -> all outputs 0 immediately; first IDLE after release does not emit a gnt unless a req is present.
- Single write then read, master 0:
  - Write addr 0x005, data 0xA5 -> m0_gnt one cycle with bram_en=1, bram_we=1, bram_addr=0x005, bram_wdata=0xA5; no rvalid.
  - Then read 0x005 with the BRAM model -> m0_rvalid one cycle later, rdata=0xA5.
- Simultaneous requests from reset: m0 reads 0x010, m1 reads 0x020, both held -> m0 served first. m0 re-requests in RESP -> m1 served next, then m0. Grants alternate over 6 accesses, each 3 cycles apart.
- Contention with single requester: m1 holds req continuously with m0 idle -> m1 granted every 3 cycles. m0 asserts mid-sequence -> m0 granted at the next IDLE.
- Reset mid-access: assert rst_n=0 during ISSUE of an m1 read -> no m1_rvalid. After release, IDLE; re-presented request completes normally.
- Address boundaries: read/write at addr 0x000 and 0x7FF (ADDR_W=11) -> bram_addr matches exactly; data round-trips.
